// File: rtl/step_debouncer.sv
// Push-button conditioner: two-flop synchronizer, debounce filter and a
// press/auto-repeat FSM producing single-cycle step strobes.
module step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic step_pulse,
  output logic btn_level,
  output logic repeating
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_SAT     = {RPT_W{1'b1}};
  localparam bit               REPEAT_ON   = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic             sync_meta_r;
  logic             sync_r;
  logic [DB_W-1:0]  db_cnt_r;
  logic [DB_W-1:0]  db_cnt_nxt_s;
  logic [RPT_W-1:0] rpt_cnt_r;
  logic [RPT_W-1:0] rpt_cnt_nxt_s;
  logic             differ_s;
  logic             commit_s;
  logic             commit_rise_s;
  logic             commit_fall_s;
  logic             level_nxt_s;
  logic             pulse_nxt_s;
  logic             rpt_clr_s;
  state_t           state_r;
  state_t           state_nxt_s;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= btn_in;
      sync_r      <= sync_meta_r;
    end
  end

  // Debounce filter: count consecutive disagreeing cycles, commit on the last one
  always_comb begin
    differ_s      = (sync_r != btn_level);
    commit_s      = 1'b0;
    db_cnt_nxt_s  = {DB_W{1'b0}};
    if (differ_s) begin
      if (db_cnt_r == DB_LAST) begin
        commit_s     = 1'b1;
        db_cnt_nxt_s = {DB_W{1'b0}};
      end else begin
        commit_s     = 1'b0;
        db_cnt_nxt_s = db_cnt_r + DB_W'(1);
      end
    end else begin
      commit_s     = 1'b0;
      db_cnt_nxt_s = {DB_W{1'b0}};
    end
    commit_rise_s = commit_s & sync_r;
    commit_fall_s = commit_s & ~sync_r;
    level_nxt_s   = commit_s ? sync_r : btn_level;
  end

  // Press / auto-repeat FSM; a release always beats a coinciding repeat expiry
  always_comb begin
    state_nxt_s = state_r;
    pulse_nxt_s = 1'b0;
    rpt_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (commit_rise_s) begin
          state_nxt_s = HELD;
          pulse_nxt_s = 1'b1;
          rpt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HELD: begin
        if (commit_fall_s) begin
          state_nxt_s = IDLE;
          rpt_clr_s   = 1'b1;
        end else if (REPEAT_ON && (rpt_cnt_r == DELAY_LAST)) begin
          state_nxt_s = REPEAT;
          pulse_nxt_s = 1'b1;
          rpt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = HELD;
        end
      end
      REPEAT: begin
        if (commit_fall_s) begin
          state_nxt_s = IDLE;
          rpt_clr_s   = 1'b1;
        end else if (rpt_cnt_r == PERIOD_LAST) begin
          pulse_nxt_s = 1'b1;
          rpt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = REPEAT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        rpt_clr_s   = 1'b1;
      end
    endcase
  end

  // Repeat counter: saturates so a long hold without auto-repeat never wraps
  always_comb begin
    rpt_cnt_nxt_s = rpt_cnt_r;
    if (rpt_clr_s || (state_r == IDLE)) begin
      rpt_cnt_nxt_s = {RPT_W{1'b0}};
    end else if (rpt_cnt_r != RPT_SAT) begin
      rpt_cnt_nxt_s = rpt_cnt_r + RPT_W'(1);
    end else begin
      rpt_cnt_nxt_s = rpt_cnt_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      db_cnt_r   <= {DB_W{1'b0}};
      rpt_cnt_r  <= {RPT_W{1'b0}};
      btn_level  <= 1'b0;
      step_pulse <= 1'b0;
      repeating  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      db_cnt_r   <= db_cnt_nxt_s;
      rpt_cnt_r  <= rpt_cnt_nxt_s;
      btn_level  <= level_nxt_s;
      step_pulse <= pulse_nxt_s;
      repeating  <= (state_nxt_s == REPEAT);
    end
  end

endmodule
